// File: rtl/ahb_arbiter_if.sv
// Arbitration-side AHB signals: per-master requests/locks, the muxed transfer
// controls the arbiter snoops, and the grant/owner outputs it drives.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MID_WIDTH   = 4
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MID_WIDTH-1:0]   HMASTER;
    logic                   HMASTLOCK;

    // Arbiter side: consumes requests and bus status, drives grant/owner.
    modport master (
        input  HBUSREQ,
        input  HLOCK,
        input  HTRANS,
        input  HBURST,
        input  HREADY,
        input  HRESP,
        output HGRANT,
        output HMASTER,
        output HMASTLOCK
    );

    // Bus/master side: raises requests, observes grant/owner.
    modport slave (
        output HBUSREQ,
        output HLOCK,
        output HTRANS,
        output HBURST,
        output HREADY,
        output HRESP,
        input  HGRANT,
        input  HMASTER,
        input  HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: never breaks fixed-length bursts or locked sequences,
// parks the bus on DEFAULT_MASTER when nobody is requesting.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MID_WIDTH      = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

    logic [3:0]       beats_left;
    logic [3:0]       beats_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_idx;
    logic             locked;
    logic             arb_point;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Beats still owed by the current fixed-length burst after this edge.
    always_comb begin
        beats_next = beats_left;
        if (bus.HRESP != RESP_OKAY) begin
            beats_next = 4'd0;
        end else begin
            case (bus.HTRANS)
                TRANS_NONSEQ: begin
                    case (bus.HBURST)
                        3'd2, 3'd3: beats_next = 4'd3;
                        3'd4, 3'd5: beats_next = 4'd7;
                        3'd6, 3'd7: beats_next = 4'd15;
                        default:    beats_next = 4'd0;
                    endcase
                end
                TRANS_SEQ: begin
                    if (beats_left != 4'd0)
                        beats_next = beats_left - 4'd1;
                end
                default: beats_next = beats_left;
            endcase
        end
    end

    assign locked    = bus.HLOCK[grant_idx];
    assign arb_point = bus.HREADY && !locked && (beats_next == 4'd0);

    // Search starts just after the current owner and reaches it last.
    always_comb begin
        int               cand;
        logic             found;
        logic [IDX_W-1:0] cand_idx;
        next_idx = DEF_IDX;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(grant_idx) + i;
            if (cand >= NUM_MASTERS)
                cand = cand - NUM_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!found && bus.HBUSREQ[cand_idx]) begin
                found    = 1'b1;
                next_idx = cand_idx;
            end
        end
    end

    // HREADY low freezes everything, including the owner handover.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            beats_left    <= 4'd0;
            grant_idx     <= DEF_IDX;
            bus.HGRANT    <= onehot(DEF_IDX);
            bus.HMASTER   <= MID_WIDTH'(DEF_IDX);
            bus.HMASTLOCK <= 1'b0;
        end else if (bus.HREADY) begin
            beats_left    <= beats_next;
            bus.HMASTER   <= MID_WIDTH'(grant_idx);
            bus.HMASTLOCK <= locked;
            if (arb_point) begin
                grant_idx  <= next_idx;
                bus.HGRANT <= onehot(next_idx);
            end
        end
    end

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot(bus.HGRANT));
    a_master_range: assert property (@(posedge HCLK) disable iff (!HRESETn)
        bus.HMASTER < MID_WIDTH'(NUM_MASTERS));
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Central AHB bus arbiter for up to `NUM_MASTERS` masters sharing one AHB address/data bus. It samples each master's bus request and lock and the shared bus's transfer-control signals, and issues a one-hot `HGRANT`. It drives `HMASTER` (address/data mux select) and `HMASTLOCK` to slaves. Fixed-length bursts and locked sequences are never broken; arbitration is round-robin, and a default master holds the bus when nobody requests.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of masters (2..16).
- `MID_WIDTH`, 4: width of `HMASTER`; ≥ clog2(`NUM_MASTERS`).
- `DEFAULT_MASTER`, 0: master granted when no requests; also the reset owner.

Ports:
- `HCLK`  in  1  bus clock. One clock; all state on rising edge.
- `HRESETn`  in  1  reset, synchronous, active-low.
- `HBUSREQ`  in  `NUM_MASTERS`  per-master bus request.
- `HLOCK`  in  `NUM_MASTERS`  per-master locked-transfer request.
- `HTRANS`  in  2  muxed bus transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HBURST`  in  3  muxed burst: 0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16.
- `HREADY`  in  1  bus ready.
- `HRESP`  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- `HGRANT`  out  `NUM_MASTERS`  one-hot grant, registered.
- `HMASTER`  out  `MID_WIDTH`  index of the current address-phase owner, registered.
- `HMASTLOCK`  out  1  current transfer is locked, registered.

## Operation
- **Reset** (`HRESETn`=0 at an edge):
  - `HGRANT` = one-hot(`DEFAULT_MASTER`); `HMASTER` = `DEFAULT_MASTER`; `HMASTLOCK` = 0.
  - `beats_left` = 0; round-robin pointer = `DEFAULT_MASTER`.
  - Reset mid-burst discards all burst and lock state.
- **Burst tracker** `beats_left` (4 bits). Updates only on edges with `HREADY`=1:
  - NONSEQ with a fixed burst loads L-1 (L = 4, 8, 16 for codes 2–7).
  - NONSEQ with SINGLE or INCR loads 0.
  - SEQ decrements when `beats_left` > 0.
  - BUSY and IDLE hold the value.
  - `HRESP` ≠ OKAY forces 0, overriding the above. This covers the second response cycle of ERROR, RETRY or SPLIT; SPLIT is treated as RETRY, with no split-mask bookkeeping.
- **Granted index** `g` = the set bit of `HGRANT`. **Locked** = `HLOCK[g]`=1.
- **Arbitration point:** an edge where `HREADY`=1, not locked, and the next value of `beats_left` = 0.
  - INCR (undefined length) and SINGLE transfers therefore allow re-arbitration on every accepted beat.
- **At an arbitration point:**
  - With any `HBUSREQ` set, the new grant is the first requester searching `g`+1, `g`+2, … modulo `NUM_MASTERS`, wrapping back to `g` itself last.
  - With none set, `HGRANT` = one-hot(`DEFAULT_MASTER`).
- **Outside arbitration points:** `HGRANT` holds.
- **Handover:** on every edge with `HREADY`=1, `HMASTER` ← `g` and `HMASTLOCK` ← `HLOCK[g]`, both using the pre-edge values. Both hold when `HREADY`=0.
- **Invariants:**
  - `HGRANT` is always exactly one-hot.
  - `HMASTER` < `NUM_MASTERS`.
  - Upper `HMASTER` bits are 0.

## Timing
- Grant latency: a request is asserted before edge E at an arbitration point, with the previous owner released. `HGRANT` changes after E. `HMASTER` follows at the next `HREADY`=1 edge, i.e. the new owner's first address phase is 1 cycle after the grant when `HREADY`=1.
- Fixed burst of L beats: the grant moves at the edge accepting the final SEQ address. Earlier beats never move the grant, including across BUSY cycles and `HREADY`=0 wait states.
- Locked owner keeps the grant while `HLOCK[g]`=1, regardless of other requests. Re-arbitration resumes at the first `HREADY`=1 edge after `HLOCK[g]` falls.
- A non-OKAY response completing with `HREADY`=1 is an arbitration point unless locked.
- `HREADY`=0 freezes all state; nothing changes.
- Simultaneous requests are resolved by the round-robin order only. No fixed priority, except `DEFAULT_MASTER` when idle.

## Test plan
- **Reset:** hold `HRESETn`=0 for 3 cycles with `HBUSREQ`=4'b1111 → `HGRANT`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0. The first grant after release is to master 1.
- **Round-robin:** `HBUSREQ`=4'b1111, SINGLE NONSEQ each beat, `HREADY`=1 → grants cycle 1, 2, 3, 0, 1. `HMASTER` lags `HGRANT` by 1 cycle.
- **Fixed burst:** master 2 issues INCR4 (NONSEQ + 3 SEQ, one BUSY inserted, two `HREADY`=0 waits) while master 3 requests → `HGRANT` stays 4'b0100 until the 4th beat's accepted edge, then becomes 4'b1000.
- **Lock:** master 1 holds `HLOCK`=1 for 6 transfers while others request → `HGRANT`=4'b0010 and `HMASTLOCK`=1 throughout. After `HLOCK` drops, the grant moves to master 2.
- **Error termination:** master 0 in WRAP8 gets ERROR on beat 3 (`HREADY` 0 then 1) → `beats_left`=0 and the grant moves to the next requester at that edge.
- **Idle:** all `HBUSREQ`=0 after traffic → `HGRANT` returns to one-hot(`DEFAULT_MASTER`) at the next arbitration point. Sweep `DEFAULT_MASTER`=2 and `NUM_MASTERS`=3.
